// File: rtl/seg_scan_ctrl.sv
// Four-digit multiplexed 7-segment scanner with double-buffered patterns; outputs registered (1-cycle latency).
// Writes are never back-pressured. Optional inter-digit blanking when SEG_SCAN_BLANK_EN is defined.
module seg_scan_ctrl #(
  parameter int DIV       = 50000,
  parameter int BLANK_CYC = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       wr_en,
  input  logic [1:0] wr_addr,
  input  logic [6:0] wr_data,
  output logic       en_a,
  output logic       en_b,
  output logic       en_c,
  output logic       en_d,
  output logic [1:0] sel,
  output logic [6:0] seg,
  output logic       frame_done
);

  localparam int MAXC = (DIV > BLANK_CYC) ? DIV : BLANK_CYC;
  localparam int CW   = $clog2(MAXC);
  localparam logic [CW-1:0] SHOW_LAST = CW'(DIV - 1);

`ifdef SEG_SCAN_BLANK_EN
  typedef enum logic [1:0] {IDLE = 2'd0, BLANK = 2'd1, SHOW = 2'd2} state_t;
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);
  localparam state_t GAP = BLANK;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, SHOW = 2'd2} state_t;
  localparam state_t GAP = SHOW;
`endif

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [1:0]      sel_q, sel_d;
  logic            pending_q, pending_d;
  logic [3:0][6:0] shadow_q, shadow_d;
  logic [3:0][6:0] active_q, active_d;
  logic [3:0]      an_q, an_d;
  logic [6:0]      seg_q, seg_d;
  logic            fd_q, fd_d;
  logic            commit;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    fd_d    = 1'b0;
    commit  = 1'b0;
    case (state_q)
      IDLE: begin
        commit = pending_q;
        cnt_d  = '0;
        sel_d  = '0;
        if (en) state_d = GAP;
      end
`ifdef SEG_SCAN_BLANK_EN
      BLANK: begin
        if (cnt_q == BLANK_LAST) begin
          state_d = SHOW;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`endif
      SHOW: begin
        if (cnt_q == SHOW_LAST) begin
          state_d = GAP;
          cnt_d   = '0;
          sel_d   = sel_q + 2'd1;
          // Frame boundary: the only point besides IDLE where new patterns go live.
          if (sel_q == 2'd3) begin
            fd_d   = 1'b1;
            commit = pending_q;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (!en) begin
      state_d = IDLE;
      cnt_d   = '0;
      sel_d   = '0;
      fd_d    = 1'b0;
    end

    // Commit reads the pre-edge shadow, so a same-cycle write stays pending.
    pending_d = wr_en | (pending_q & ~commit);
    shadow_d  = shadow_q;
    if (wr_en) shadow_d[wr_addr] = wr_data;
    active_d  = commit ? shadow_q : active_q;

    an_d  = 4'hF;
    seg_d = 7'h7F;
    if (state_d == SHOW) begin
      an_d[sel_d] = 1'b0;
      seg_d       = active_d[sel_d];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      sel_q     <= '0;
      pending_q <= 1'b0;
      shadow_q  <= {4{7'h7F}};
      active_q  <= {4{7'h7F}};
      an_q      <= 4'hF;
      seg_q     <= 7'h7F;
      fd_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sel_q     <= sel_d;
      pending_q <= pending_d;
      shadow_q  <= shadow_d;
      active_q  <= active_d;
      an_q      <= an_d;
      seg_q     <= seg_d;
      fd_q      <= fd_d;
    end
  end

  assign en_a       = an_q[0];
  assign en_b       = an_q[1];
  assign en_c       = an_q[2];
  assign en_d       = an_q[3];
  assign sel        = sel_q;
  assign seg        = seg_q;
  assign frame_done = fd_q;

endmodule

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 SHALL have parameter DIV, default 50000, clock cycles each digit is lit (minimum 2).
REQ-002 SHALL have parameter BLANK_CYC, default 16, clock cycles of all-anodes-off between digits (minimum 1).
REQ-003 SHALL have port clk, input, 1, sole clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port en, input, 1, scan enable.
REQ-006 SHALL have port wr_en, input, 1, shadow-register write strobe.
REQ-007 SHALL have port wr_addr, input, 2, digit index for the write (0=A, 1=B, 2=C, 3=D).
REQ-008 SHALL have port wr_data, input, 7, active-low segment pattern {g,f,e,d,c,b,a}.
REQ-009 SHALL have ports en_a, en_b, en_c, en_d, output, 1 each, active-low anode enables.
REQ-010 SHALL have port sel, output, 2, index of the digit currently scanned.
REQ-011 SHALL have port seg, output, 7, active-low segment drive.
REQ-012 SHALL have port frame_done, output, 1, one-cycle pulse at the end of each digit-D slot.

Function
REQ-013 SHALL hold two banks of four 7-bit patterns: shadow (written) and active (displayed).
REQ-014 wr_en=1 SHALL write wr_data to shadow[wr_addr] at the clock edge and set flag pending; writes accepted in every state, no back-pressure.
REQ-015 SHALL implement states IDLE, BLANK and SHOW; all outputs registered.
REQ-016 IDLE: anodes all 1, seg=7'h7F, sel=0, counter=0; when pending=1, copy shadow to active and clear pending.
REQ-017 IDLE with en=1 SHALL go to BLANK (SHOW when BLANK_EN undefined), sel=0.
REQ-018 BLANK: anodes all 1, seg=7'h7F; after exactly BLANK_CYC cycles SHALL go to SHOW.
REQ-019 SHOW: only the anode selected by sel low, seg=active[sel]; after exactly DIV cycles SHALL increment sel modulo 4 and go to BLANK (SHOW when BLANK_EN undefined).
REQ-020 On leaving SHOW with sel=3, SHALL pulse frame_done for one cycle and, when pending=1, copy shadow to active and clear pending.
REQ-021 A write in the same cycle as a commit SHALL not appear in that commit; pending SHALL remain set, so the data is committed at the next frame boundary.
REQ-022 en=0 in any state SHALL force IDLE at the next edge: anodes all 1, seg=7'h7F, sel=0, counter cleared, frame_done=0; a re-enable always restarts at digit A.
REQ-023 The dwell counter SHALL be $clog2(max(DIV,BLANK_CYC)) bits wide and never wrap inside a state.
REQ-024 At most one anode SHALL be low in any cycle.

Reset
REQ-025 rst_n=0 SHALL immediately, without a clock, force state IDLE, en_a..en_d=1, seg=7'h7F, sel=0, frame_done=0, counter=0, pending=0, and all shadow and active entries to 7'h7F.
REQ-026 After rst_n rises, the first state change SHALL occur at the first rising clk edge.

Configuration
REQ-027 Macro SEG_SCAN_BLANK_EN defined: BLANK state present, frame = 4*(DIV+BLANK_CYC) cycles.
REQ-028 Macro SEG_SCAN_BLANK_EN undefined: BLANK state and BLANK_CYC unused, SHOW to SHOW directly, frame = 4*DIV cycles; all other requirements unchanged.

Verification (DIV=4, BLANK_CYC=2, SEG_SCAN_BLANK_EN defined unless stated)
REQ-029 Write A=7'b0000010, B=7'b0000000, C=7'b0010010, D=7'b1111000 in IDLE, then raise en -> 2 cycles all-off, en_a low 4 cycles with seg=7'b0000010, 2 off, en_b low 4 cycles with seg=7'b0000000, ...; frame_done pulse every 24 cycles.
REQ-030 Write B=7'b1111001 while en_b is low -> seg unchanged for the rest of the frame; 7'b1111001 appears on the next en_b slot after frame_done.
REQ-031 Drop en during the en_c slot -> next cycle anodes 4'b1111, seg=7'h7F, sel=0; re-raise -> scan resumes at digit A after 2 blank cycles.
REQ-032 Assert rst_n=0 between clock edges during SHOW -> outputs go to reset values before the next edge; shadow and active read back 7'h7F.
REQ-033 Write in the frame_done cycle -> not visible in the next frame's digit slot; visible one frame later.
REQ-034 SEG_SCAN_BLANK_EN undefined -> no all-off cycles, each anode low 4 cycles back-to-back, frame_done every 16 cycles.
